// File: rtl/muldiv_unit.sv
// muldiv_unit: radix-2 iterative multiply/divide engine for MULT, MULTU, DIV, DIVU.
// Drives the HI/LO write strobes and registered write data. One shift-add or
// restoring-subtract step per clock, then one sign-fix cycle, then a one-cycle
// done/write pulse.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             hi_we,
  output logic             lo_we,
  output logic [WIDTH-1:0] hi_wdata,
  output logic [WIDTH-1:0] lo_wdata
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              is_div_q, is_div_d;     // op[1]: divide when set
  logic              is_sgn_q, is_sgn_d;     // op[0]==0: signed op
  logic              neg_q, neg_d;           // sign(a) ^ sign(b)
  logic              sa_q, sa_d;             // sign(a), remainder sign
  logic              bzero_q, bzero_d;       // divisor was zero
  logic [WIDTH-1:0]  araw_q, araw_d;         // raw dividend for the b=0 case
  logic [WIDTH-1:0]  bmag_q, bmag_d;         // multiplicand (mul) / divisor (div)
  logic [2*WIDTH-1:0] acc_q, acc_d;          // mul: product/multiplier; div: low half = dividend/quotient
  logic [WIDTH-1:0]  rem_q, rem_d;           // settled remainder (always < divisor)
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;

  // Operand magnitudes: signed ops negate negative inputs; 0x80..0 maps to itself.
  logic             in_sgn;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign in_sgn = ~op[0];
  assign a_mag  = (in_sgn && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_mag  = (in_sgn && b[WIDTH-1]) ? (~b + 1'b1) : b;

  // Multiply step: add multiplicand into the upper half when the LSB is set, then shift right.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, bmag_q} : '0);

  // Divide step: the W+1-bit partial remainder is trial-subtracted; the W+1-bit
  // wrapped difference carries the correct sign because |diff| < divisor < 2^W.
  logic [WIDTH:0] div_shift, div_trial;
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, bmag_q};

  // Sign-corrected results used in the FIX cycle.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  assign prod_fix = (is_sgn_q && neg_q) ? (~acc_q + 1'b1) : acc_q;
  assign quot_fix = (is_sgn_q && neg_q) ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign rem_fix  = (is_sgn_q && sa_q)  ? (~rem_q + 1'b1) : rem_q;

  // Next-state logic for the control FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == LAST_CNT) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: operand latch, iteration step, sign fix and result load.
  always_comb begin
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    is_sgn_d = is_sgn_q;
    neg_d    = neg_q;
    sa_d     = sa_q;
    bzero_d  = bzero_q;
    araw_d   = araw_q;
    bmag_d   = bmag_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d    = '0;
          is_div_d = op[1];
          is_sgn_d = in_sgn;
          neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
          sa_d     = a[WIDTH-1];
          bzero_d  = (b == '0);
          araw_d   = a;
          rem_d    = '0;
          if (op[1]) begin
            bmag_d = b_mag;
            acc_d  = {{WIDTH{1'b0}}, a_mag};
          end else begin
            bmag_d = a_mag;
            acc_d  = {{WIDTH{1'b0}}, b_mag};
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (!is_div_q) begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (!div_trial[WIDTH]) begin
          rem_d = div_trial[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = div_shift[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
        end
      end
      FIX: begin
        cnt_d = '0;
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (bzero_q) begin
          hi_d = araw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers; reset clears everything including the results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      is_sgn_q <= 1'b0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      bzero_q  <= 1'b0;
      araw_q   <= '0;
      bmag_q   <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      is_sgn_q <= is_sgn_d;
      neg_q    <= neg_d;
      sa_q     <= sa_d;
      bzero_q  <= bzero_d;
      araw_q   <= araw_d;
      bmag_q   <= bmag_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign hi_we    = done;
  assign lo_we    = done;
  assign hi_wdata = hi_q;
  assign lo_wdata = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with a scoreboard queue; a negedge monitor
// pops an expected HI/LO/latency entry on every done pulse.
module tb_muldiv_unit;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;
  localparam int LAT = 33;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, hi_we, lo_we;
  logic [31:0] hi_wdata, lo_wdata;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi_we(hi_we), .lo_we(lo_we),
    .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: checks every done pulse against the scoreboard head.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      done_prev = 1'b0;
    end else begin
      if (done_prev) chk("done_width", {63'd0, done}, 64'd0);
      if (!done && (hi_we || lo_we)) chk("stray_we", {62'd0, hi_we, lo_we}, 64'd0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk({e.name, " hi"}, {32'd0, hi_wdata}, {32'd0, e.hi});
          chk({e.name, " lo"}, {32'd0, lo_wdata}, {32'd0, e.lo});
          chk({e.name, " cycle"}, 64'(cyc), 64'(e.cyc));
          chk({e.name, " we"}, {62'd0, hi_we, lo_we}, 64'd3);
        end
      end
      done_prev = done;
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int t);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    t = cyc;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic expect_res(input string name, input logic [31:0] h, input logic [31:0] l, input int t);
    exp_t e;
    e.name = name; e.hi = h; e.lo = l; e.cyc = t + LAT;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 100 && busy; k++) @(negedge clk);
    if (busy) chk({name, " timeout"}, 64'd1, 64'd0);
  endtask

  task automatic run(input string name, input logic [1:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] h, input logic [31:0] l);
    int t;
    issue(o, x, y, t);
    expect_res(name, h, l, t);
    wait_idle(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset strobes", {61'd0, done, hi_we, lo_we}, 64'd0);
    chk("reset wdata", {hi_wdata, lo_wdata}, 64'd0);

    run("multu_ffff", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run("mult_m3x7",  OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run("mult_min2",  OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run("div_m7d2",   OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run("divu_100d7", OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E);
    run("divu_by0",   OP_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF);
    run("div_min_by0",OP_DIV,   32'h80000000, 32'h00000000, 32'h80000000, 32'hFFFFFFFF);
    run("div_min_m1", OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // Start pulses during CALC and DONE must be ignored.
    issue(OP_MULTU, 32'd3, 32'd5, t);
    expect_res("ign_first", 32'h0, 32'hF, t);
    repeat (5) @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd9; b = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 100 && !done; k++) @(negedge clk);
    if (!done) chk("ign_first done timeout", 64'd1, 64'd0);
    start = 1'b1; op = OP_DIVU; a = 32'd11; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    chk("ign_done busy", {63'd0, busy}, 64'd0);
    // Next start, in the first IDLE cycle, is accepted.
    run("first_idle", OP_MULTU, 32'h10, 32'h10, 32'h0, 32'h100);

    // Reset at CALC cnt=10: aborts with no strobe and clears the results.
    issue(OP_MULTU, 32'h12345678, 32'h9, t);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst busy", {63'd0, busy}, 64'd0);
    chk("midrst done", {63'd0, done}, 64'd0);
    chk("midrst wdata", {hi_wdata, lo_wdata}, 64'd0);
    run("multu_6x7", OP_MULTU, 32'd6, 32'd7, 32'h0, 32'd42);

    repeat (5) @(negedge clk);
    chk("scoreboard empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
